// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and capture FSM encodings
// for the Uart receive-side FIFO.
package uart_rx_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACK        = 2'd1,
    WAIT_CLEAR = 2'd2
  } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Uart read side plus consumer valid/ready
// bundle for uart_rx_fifo.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);

  logic                  uart_ready_i;
  logic [DATA_WIDTH-1:0] uart_data_i;
  logic                  uart_ack_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DEPTH_LOG2:0]   count_o;
  logic                  overflow_o;
  logic                  clear_overflow_i;

  modport slave (
    input  uart_ready_i,
    input  uart_data_i,
    input  ready_i,
    input  clear_overflow_i,
    output uart_ack_o,
    output data_o,
    output valid_o,
    output count_o,
    output overflow_o
  );

  modport master (
    output uart_ready_i,
    output uart_data_i,
    output ready_i,
    output clear_overflow_i,
    input  uart_ack_o,
    input  data_o,
    input  valid_o,
    input  count_o,
    input  overflow_o
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic circular FIFO: pointers, occupancy
// count and register-array storage.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          push_ok
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign pop_ok = pop & ~empty;
  // a pop in the same cycle frees the slot a full push needs
  assign push_ok = push & (~full | pop_ok);
  assign rdata  = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures Uart receive bytes with an ack
// handshake and buffers them for a consumer.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic           clock_i,
  input logic           reset_i,
  uart_rx_fifo_if.slave bus
);

  cap_state_t state;
  cap_state_t state_next;
  logic       push_req;
  logic       push_ok;
  logic       empty;
  logic       ack_q;
  logic       ovf_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.uart_ready_i) begin
          push_req   = 1'b1;
          state_next = ACK;
        end
      end
      ACK:        state_next = WAIT_CLEAR;
      WAIT_CLEAR: if (!bus.uart_ready_i) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // ack is its own flop so it stays glitch-free toward the Uart
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= (state_next == ACK);
      if (push_req && !push_ok)  ovf_q <= 1'b1;
      else if (bus.clear_overflow_i) ovf_q <= 1'b0;
    end
  end

  sync_fifo #(
    .DW (DATA_WIDTH),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clock_i),
    .rst     (reset_i),
    .push    (push_req),
    .wdata   (bus.uart_data_i),
    .pop     (bus.ready_i),
    .rdata   (bus.data_o),
    .count   (bus.count_o),
    .empty   (empty),
    .push_ok (push_ok)
  );

  assign bus.valid_o    = ~empty;
  assign bus.uart_ack_o = ack_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the Uart core's read interface. Captures each byte the Uart flags with read_ready_o and acknowledges it. Stores bytes in a small circular FIFO and presents them to a consumer over a valid/ready handshake. This decouples consumer stalls from the serial line and reports dropped bytes through a sticky overflow flag.

Parameters:
DATA_WIDTH, 8, width of each received byte; matches Uart data_o.
DEPTH_LOG2, 3, log2 of FIFO depth; default depth is 8 entries.

Ports:
clock_i  input  1  system clock; all logic on rising edge.
reset_i  input  1  asynchronous, active-high reset.
uart_ready_i  input  1  from Uart read_ready_o; a received byte is pending.
uart_data_i  input  DATA_WIDTH  from Uart data_o; valid while uart_ready_i=1.
uart_ack_o  output  1  to Uart ack_i; one-cycle pulse per captured byte.
data_o  output  DATA_WIDTH  head-of-FIFO byte.
valid_o  output  1  FIFO non-empty; data_o is valid.
ready_i  input  1  consumer accepts data_o when valid_o=1.
count_o  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
overflow_o  output  1  sticky flag: a byte was dropped because the FIFO was full.
clear_overflow_i  input  1  synchronous clear of overflow_o.

Behaviour:
- Reset, asynchronous on reset_i rising:
  - Write pointer and read pointer are 0; count_o=0.
  - valid_o=0, uart_ack_o=0, overflow_o=0.
  - Capture FSM goes to IDLE.
  - FIFO memory contents are don't-care; data_o is don't-care while valid_o=0.
- Capture FSM, states IDLE, ACK, WAIT_CLEAR:
  - IDLE: if uart_ready_i=1, perform a push attempt on uart_data_i and go to ACK.
  - ACK: uart_ack_o=1 for exactly this cycle. Next state is WAIT_CLEAR.
  - WAIT_CLEAR: stay while uart_ready_i=1; return to IDLE when uart_ready_i=0. This prevents double-capture while the Uart deasserts read_ready_o after the ack.
  - uart_ack_o is a registered output, high only in ACK.
- Push attempt (IDLE->ACK edge):
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Accepted: memory[wptr]<=uart_data_i and wptr increments.
  - Not accepted: the byte is dropped and overflow_o<=1.
  - The byte is acked in both cases, so the Uart is always drained.
- Pop: occurs when valid_o=1 and ready_i=1; rptr increments.
- Pointers are DEPTH_LOG2 bits and wrap naturally modulo DEPTH.
- count_o update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including the case count=DEPTH.
  - Never exceeds DEPTH; never underflows.
- Output timing:
  - valid_o = (count_o != 0).
  - data_o = memory[rptr], combinational read of the registered array.
  - Latency: a byte captured on edge N appears on data_o/valid_o after edge N, i.e. one cycle after uart_ready_i is sampled.
- Empty FIFO:
  - ready_i is ignored; no pop.
  - A same-cycle push is not bypassed; data appears the next cycle.
- overflow_o:
  - Set by a dropped byte.
  - Cleared by clear_overflow_i=1.
  - If set and clear coincide, set wins.
- Reset mid-operation:
  - Aborts any pending ack.
  - If the Uart still holds read_ready_o after reset, that byte is captured fresh from IDLE.

Decomposition:
- Shared package/include: default DATA_WIDTH and DEPTH_LOG2 constants, and the FSM state encodings (IDLE=2'd0, ACK=2'd1, WAIT_CLEAR=2'd2).
- One natural sub-module: sync_fifo, a generic pointer/count/memory FIFO with push/pop/full/empty.
- uart_rx_fifo wraps sync_fifo with the capture FSM and overflow logic.

Test Plan:
- Single byte: uart_ready_i=1 with data 8'hA5, held 3 cycles then dropped, ready_i=0.
  -> Exactly one uart_ack_o pulse, count_o=1, valid_o=1, data_o=8'hA5.
  -> No second capture while ready stays high.
- Fill and order: push 8'h01..8'h08, then ready_i=1.
  -> count_o reaches 8.
  -> Pops return 01..08 in order, pointers wrap, count_o returns to 0, valid_o=0.
- Overflow: FIFO full with 8 bytes, then push 8'hFF with ready_i=0.
  -> uart_ack_o still pulses, count_o stays 8, overflow_o=1, FIFO contents unchanged.
  -> clear_overflow_i pulse drops overflow_o to 0.
- Full with simultaneous pop: count=8, ready_i=1 on the same cycle the push of 8'h55 is attempted.
  -> Push accepted, count_o stays 8, overflow_o=0, 8'h55 is the last byte popped.
- Async reset mid-ack: assert reset_i during the ACK state.
  -> uart_ack_o drops immediately, count_o=0, valid_o=0.
  -> After release with uart_ready_i still 1, one new capture and ack occur.
- Back-to-back streaming: consumer ready_i=1 continuously while 20 bytes arrive with 2-cycle gaps.
  -> All 20 bytes received in order, count_o never exceeds 1, overflow_o=0.
